// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the I/D memory bus arbiter.
//   mem_req_t   - one latched downstream request (address, direction, size, byte enables, data)
//   arb_state_t - arbiter FSM states
//   MSIZE_WORD  - access size used for every instruction fetch (4 bytes)
package mem_bus_arbiter_pkg;

    // Widest address any instance may use; narrower instances zero-extend into it.
    localparam int unsigned ADDR_MAX_W = 64;

    localparam logic [2:0] MSIZE_WORD = 3'd2;

    typedef enum logic [2:0] {
        StIdle,
        StReqI,
        StReqD,
        StWaitI,
        StWaitD
    } arb_state_t;

    typedef struct packed {
        logic [ADDR_MAX_W-1:0] addr;
        logic                  write;
        logic [2:0]            size;
        logic [7:0]            strobe;
        logic [63:0]           wdata;
    } mem_req_t;

    // Pick the 32-bit half of a 64-bit beat that holds the fetched instruction.
    function automatic logic [31:0] word_select(logic [63:0] beat, logic upper);
        return upper ? beat[63:32] : beat[31:0];
    endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// Starvation counter for the fetch side of the memory bus arbiter.
// Counts data-side grants made while a fetch was waiting; once it reaches STARVE_LIMIT the
// fetch side is forced to win the next contested grant.
//   clk, reset  - clock, asynchronous active-high reset
//   grant_i     - fetch side granted this cycle (clears the count)
//   grant_d     - data side granted this cycle
//   i_waiting   - fetch request pending while the data grant is made
//   force_i     - count has reached the limit; fetch must win
module arb_starve_ctr #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic grant_i,
    input  logic grant_d,
    input  logic i_waiting,
    output logic force_i
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= 4'd0;
        end else if (grant_i) begin
            count <= 4'd0;
        end else if (grant_d && i_waiting && (count != LIMIT)) begin
            count <= count + 4'd1;
        end
    end

    assign force_i = (count == LIMIT);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one downstream memory port between instruction fetch (I) and data access (D).
// One transaction is outstanding at a time: a requester is granted in IDLE, its request is
// latched and presented downstream (REQ_x) until accepted, then the single response beat is
// forwarded (WAIT_x) and the arbiter returns to IDLE.
//   clk, reset                     - clock, asynchronous active-high reset
//   ireq_*  / iresp_*              - fetch side, addr_ok/data_ok protocol, 32-bit data
//   dreq_*  / dresp_*              - data side, addr_ok/data_ok protocol, 64-bit data
//   mreq_*  (valid/ready)          - downstream request, fields held stable until ready
//   mresp_valid, mresp_data        - downstream single-beat response
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W       = 64,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              ireq_valid,
    input  logic [ADDR_W-1:0] ireq_addr,
    output logic              iresp_addr_ok,
    output logic              iresp_data_ok,
    output logic [31:0]       iresp_data,

    input  logic              dreq_valid,
    input  logic [ADDR_W-1:0] dreq_addr,
    input  logic [2:0]        dreq_size,
    input  logic [7:0]        dreq_strobe,
    input  logic [63:0]       dreq_wdata,
    output logic              dresp_addr_ok,
    output logic              dresp_data_ok,
    output logic [63:0]       dresp_data,

    output logic              mreq_valid,
    input  logic              mreq_ready,
    output logic [ADDR_W-1:0] mreq_addr,
    output logic              mreq_write,
    output logic [2:0]        mreq_size,
    output logic [7:0]        mreq_strobe,
    output logic [63:0]       mreq_wdata,
    input  logic              mresp_valid,
    input  logic [63:0]       mresp_data
);

    arb_state_t state;
    mem_req_t   req;
    mem_req_t   i_req;
    mem_req_t   d_req;
    logic       grant_i;
    logic       grant_d;
    logic       force_i;

    arb_starve_ctr #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve_ctr (
        .clk      (clk),
        .reset    (reset),
        .grant_i  (grant_i),
        .grant_d  (grant_d),
        .i_waiting(ireq_valid),
        .force_i  (force_i)
    );

    // Grants only happen in IDLE; D wins ties unless the fetch side has been starved.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state == StIdle) begin
            if (ireq_valid && (!dreq_valid || force_i)) begin
                grant_i = 1'b1;
            end else if (dreq_valid) begin
                grant_d = 1'b1;
            end
        end
    end

    // Candidate latch contents for each side.
    always_comb begin
        i_req      = '0;
        i_req.addr = ADDR_MAX_W'(ireq_addr);
        i_req.size = MSIZE_WORD;

        d_req        = '0;
        d_req.addr   = ADDR_MAX_W'(dreq_addr);
        d_req.write  = |dreq_strobe;
        d_req.size   = dreq_size;
        d_req.strobe = dreq_strobe;
        d_req.wdata  = dreq_wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= StIdle;
            req   <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (grant_i) begin
                        req   <= i_req;
                        state <= StReqI;
                    end else if (grant_d) begin
                        req   <= d_req;
                        state <= StReqD;
                    end
                end
                StReqI: begin
                    if (mreq_ready) state <= StWaitI;
                end
                StReqD: begin
                    if (mreq_ready) state <= StWaitD;
                end
                StWaitI, StWaitD: begin
                    if (mresp_valid) state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

    // Request fields come straight from the latch, so they cannot move while REQ_x waits.
    always_comb begin
        mreq_valid  = (state == StReqI) || (state == StReqD);
        mreq_addr   = req.addr[ADDR_W-1:0];
        mreq_write  = req.write;
        mreq_size   = req.size;
        mreq_strobe = req.strobe;
        mreq_wdata  = req.wdata;

        iresp_addr_ok = (state == StReqI) && mreq_ready;
        dresp_addr_ok = (state == StReqD) && mreq_ready;

        // Responses are only recognised in WAIT_x; stray beats elsewhere are dropped.
        iresp_data_ok = (state == StWaitI) && mresp_valid;
        dresp_data_ok = (state == StWaitD) && mresp_valid;

        iresp_data = iresp_data_ok ? word_select(mresp_data, req.addr[2]) : 32'd0;
        dresp_data = dresp_data_ok ? mresp_data : 64'd0;
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: cycle vectors, hand-written corner sequences and a
// transaction-level reference model driven by random stimulus.
module tb_mem_bus_arbiter;

    localparam int unsigned ADDR_W = 64;
    localparam int          LIMIT  = 4;

    // {mreq_valid, iresp_addr_ok, iresp_data_ok, dresp_addr_ok, dresp_data_ok}
    localparam logic [4:0] C_NONE = 5'b00000;
    localparam logic [4:0] C_REQ  = 5'b10000;
    localparam logic [4:0] C_IAOK = 5'b11000;
    localparam logic [4:0] C_IDOK = 5'b00100;
    localparam logic [4:0] C_DAOK = 5'b10010;
    localparam logic [4:0] C_DDOK = 5'b00001;

    logic              clk;
    logic              reset;
    logic              ireq_valid;
    logic [ADDR_W-1:0] ireq_addr;
    logic              iresp_addr_ok;
    logic              iresp_data_ok;
    logic [31:0]       iresp_data;
    logic              dreq_valid;
    logic [ADDR_W-1:0] dreq_addr;
    logic [2:0]        dreq_size;
    logic [7:0]        dreq_strobe;
    logic [63:0]       dreq_wdata;
    logic              dresp_addr_ok;
    logic              dresp_data_ok;
    logic [63:0]       dresp_data;
    logic              mreq_valid;
    logic              mreq_ready;
    logic [ADDR_W-1:0] mreq_addr;
    logic              mreq_write;
    logic [2:0]        mreq_size;
    logic [7:0]        mreq_strobe;
    logic [63:0]       mreq_wdata;
    logic              mresp_valid;
    logic [63:0]       mresp_data;

    mem_bus_arbiter #(
        .ADDR_W      (ADDR_W),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ireq_valid   (ireq_valid),
        .ireq_addr    (ireq_addr),
        .iresp_addr_ok(iresp_addr_ok),
        .iresp_data_ok(iresp_data_ok),
        .iresp_data   (iresp_data),
        .dreq_valid   (dreq_valid),
        .dreq_addr    (dreq_addr),
        .dreq_size    (dreq_size),
        .dreq_strobe  (dreq_strobe),
        .dreq_wdata   (dreq_wdata),
        .dresp_addr_ok(dresp_addr_ok),
        .dresp_data_ok(dresp_data_ok),
        .dresp_data   (dresp_data),
        .mreq_valid   (mreq_valid),
        .mreq_ready   (mreq_ready),
        .mreq_addr    (mreq_addr),
        .mreq_write   (mreq_write),
        .mreq_size    (mreq_size),
        .mreq_strobe  (mreq_strobe),
        .mreq_wdata   (mreq_wdata),
        .mresp_valid  (mresp_valid),
        .mresp_data   (mresp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        iv;
        logic [63:0] iaddr;
        logic        dv;
        logic [63:0] daddr;
        logic [2:0]  dsize;
        logic [7:0]  dstrb;
        logic [63:0] dwdata;
        logic        rdy;
        logic        rv;
        logic [63:0] rdata;
        logic [4:0]  ctl;
        logic [63:0] maddr;
        logic        mwrite;
        logic [2:0]  msize;
        logic [7:0]  mstrb;
        logic [63:0] mwdata;
        logic [31:0] idata;
        logic [63:0] ddata;
    } vec_t;

    typedef struct {
        bit          is_i;
        bit          acc;
        logic [63:0] addr;
        logic        write;
        logic [2:0]  size;
        logic [7:0]  strb;
        logic [63:0] wdata;
    } txn_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [4:0] ctl_now();
        return {mreq_valid, iresp_addr_ok, iresp_data_ok, dresp_addr_ok, dresp_data_ok};
    endfunction

    task automatic add(input logic iv, input logic [63:0] iaddr, input logic dv,
                       input logic [63:0] daddr, input logic [2:0] dsize, input logic [7:0] dstrb,
                       input logic [63:0] dwdata, input logic rdy, input logic rv,
                       input logic [63:0] rdata, input logic [4:0] ctl, input logic [63:0] maddr,
                       input logic mwrite, input logic [2:0] msize, input logic [7:0] mstrb,
                       input logic [63:0] mwdata, input logic [31:0] idata,
                       input logic [63:0] ddata);
        vecs.push_back('{iv, iaddr, dv, daddr, dsize, dstrb, dwdata, rdy, rv, rdata,
                         ctl, maddr, mwrite, msize, mstrb, mwdata, idata, ddata});
    endtask

    task automatic clear_inputs();
        ireq_valid  = 1'b0;
        ireq_addr   = '0;
        dreq_valid  = 1'b0;
        dreq_addr   = '0;
        dreq_size   = '0;
        dreq_strobe = '0;
        dreq_wdata  = '0;
        mreq_ready  = 1'b0;
        mresp_valid = 1'b0;
        mresp_data  = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".ctl"}, 64'(ctl_now()), 64'd0);
        check({tag, ".maddr"}, mreq_addr, 64'd0);
        check({tag, ".mfields"}, 64'({mreq_write, mreq_size, mreq_strobe}), 64'd0);
        check({tag, ".mwdata"}, mreq_wdata, 64'd0);
        check({tag, ".idata"}, 64'(iresp_data), 64'd0);
        check({tag, ".ddata"}, dresp_data, 64'd0);
    endtask

    // Leaves the bench at posedge+1 of the first IDLE cycle after reset.
    task automatic apply_reset();
        clear_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          grants[$];
        int          starve;
        txn_t        pend[$];
        txn_t        t;
        logic [4:0]  e_ctl;
        logic [31:0] e_id;
        logic [63:0] e_dd;
        bit          i_win;
        bit          d_win;
        bit          iv;
        bit          dv;
        bit          rdy;
        bit          rv;

        clear_inputs();
        reset = 1'b1;
        #2 check_all_zero("in_reset");
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        // First IDLE after reset: outputs stay 0 even with requests present.
        ireq_valid = 1'b1;
        dreq_valid = 1'b1;
        #3 check_all_zero("first_idle");
        clear_inputs();
        @(posedge clk);
        #1;

        // Single fetch, upper word selected by addr[2] = 1.
        add(1'b1, 64'h8000_0004, 1'b0, '0, '0, '0, '0, 1'b1, 1'b0, '0,
            C_NONE, '0, 1'b0, '0, '0, '0, '0, '0);
        add(1'b1, 64'h8000_0004, 1'b0, '0, '0, '0, '0, 1'b1, 1'b0, '0,
            C_IAOK, 64'h8000_0004, 1'b0, 3'd2, 8'h00, '0, '0, '0);
        add(1'b0, '0, 1'b0, '0, '0, '0, '0, 1'b1, 1'b1, 64'h1111_2222_3333_4444,
            C_IDOK, '0, 1'b0, '0, '0, '0, 32'h1111_2222, '0);
        add(1'b0, '0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0, '0,
            C_NONE, '0, 1'b0, '0, '0, '0, '0, '0);
        // Data write with ready held low three cycles.
        add(1'b0, '0, 1'b1, 64'h8000_0010, 3'd2, 8'h0F, 64'hDEAD_BEEF, 1'b0, 1'b0, '0,
            C_NONE, '0, 1'b0, '0, '0, '0, '0, '0);
        for (int k = 0; k < 3; k++) begin
            add(1'b0, '0, 1'b1, 64'h8000_0010, 3'd2, 8'h0F, 64'hDEAD_BEEF, 1'b0, 1'b0, '0,
                C_REQ, 64'h8000_0010, 1'b1, 3'd2, 8'h0F, 64'hDEAD_BEEF, '0, '0);
        end
        add(1'b0, '0, 1'b1, 64'h8000_0010, 3'd2, 8'h0F, 64'hDEAD_BEEF, 1'b1, 1'b0, '0,
            C_DAOK, 64'h8000_0010, 1'b1, 3'd2, 8'h0F, 64'hDEAD_BEEF, '0, '0);
        add(1'b0, '0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0, '0,
            C_NONE, '0, 1'b0, '0, '0, '0, '0, '0);
        add(1'b0, '0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b1, 64'h0123_4567_89AB_CDEF,
            C_DDOK, '0, 1'b0, '0, '0, '0, '0, 64'h0123_4567_89AB_CDEF);
        add(1'b0, '0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0, '0,
            C_NONE, '0, 1'b0, '0, '0, '0, '0, '0);
        // Fetch whose valid drops right after grant; lower word selected.
        add(1'b1, 64'h0000_2000, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0, '0,
            C_NONE, '0, 1'b0, '0, '0, '0, '0, '0);
        add(1'b0, '0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0, '0,
            C_REQ, 64'h0000_2000, 1'b0, 3'd2, 8'h00, '0, '0, '0);
        add(1'b0, '0, 1'b0, '0, '0, '0, '0, 1'b1, 1'b0, '0,
            C_IAOK, 64'h0000_2000, 1'b0, 3'd2, 8'h00, '0, '0, '0);
        add(1'b0, '0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b1, 64'hAAAA_BBBB_CCCC_DDDD,
            C_IDOK, '0, 1'b0, '0, '0, '0, 32'hCCCC_DDDD, '0);
        add(1'b0, '0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0, '0,
            C_NONE, '0, 1'b0, '0, '0, '0, '0, '0);
        // Stray response beats in IDLE and REQ_I are ignored.
        add(1'b0, '0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF,
            C_NONE, '0, 1'b0, '0, '0, '0, '0, '0);
        add(1'b1, 64'h0000_3004, 1'b0, '0, '0, '0, '0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF,
            C_NONE, '0, 1'b0, '0, '0, '0, '0, '0);
        add(1'b1, 64'h0000_3004, 1'b0, '0, '0, '0, '0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF,
            C_REQ, 64'h0000_3004, 1'b0, 3'd2, 8'h00, '0, '0, '0);
        add(1'b1, 64'h0000_3004, 1'b0, '0, '0, '0, '0, 1'b1, 1'b0, '0,
            C_IAOK, 64'h0000_3004, 1'b0, 3'd2, 8'h00, '0, '0, '0);
        add(1'b0, '0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b1, 64'h9999_8888_7777_6666,
            C_IDOK, '0, 1'b0, '0, '0, '0, 32'h9999_8888, '0);
        add(1'b0, '0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0, '0,
            C_NONE, '0, 1'b0, '0, '0, '0, '0, '0);
        // Two back-to-back data reads; D re-granted in the IDLE right after its data_ok.
        add(1'b0, '0, 1'b1, 64'h0000_0100, 3'd3, 8'h00, '0, 1'b1, 1'b0, '0,
            C_NONE, '0, 1'b0, '0, '0, '0, '0, '0);
        add(1'b0, '0, 1'b1, 64'h0000_0100, 3'd3, 8'h00, '0, 1'b1, 1'b0, '0,
            C_DAOK, 64'h0000_0100, 1'b0, 3'd3, 8'h00, '0, '0, '0);
        add(1'b0, '0, 1'b1, 64'h0000_0108, 3'd3, 8'h00, '0, 1'b1, 1'b1, 64'h5A5A_5A5A_1234_5678,
            C_DDOK, '0, 1'b0, '0, '0, '0, '0, 64'h5A5A_5A5A_1234_5678);
        add(1'b0, '0, 1'b1, 64'h0000_0108, 3'd3, 8'h00, '0, 1'b1, 1'b0, '0,
            C_NONE, '0, 1'b0, '0, '0, '0, '0, '0);
        add(1'b0, '0, 1'b1, 64'h0000_0108, 3'd3, 8'h00, '0, 1'b1, 1'b0, '0,
            C_DAOK, 64'h0000_0108, 1'b0, 3'd3, 8'h00, '0, '0, '0);
        add(1'b0, '0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b1, 64'hC3C3_0000_FFFF_1111,
            C_DDOK, '0, 1'b0, '0, '0, '0, '0, 64'hC3C3_0000_FFFF_1111);
        add(1'b0, '0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0, '0,
            C_NONE, '0, 1'b0, '0, '0, '0, '0, '0);

        foreach (vecs[k]) begin
            ireq_valid  = vecs[k].iv;
            ireq_addr   = vecs[k].iaddr;
            dreq_valid  = vecs[k].dv;
            dreq_addr   = vecs[k].daddr;
            dreq_size   = vecs[k].dsize;
            dreq_strobe = vecs[k].dstrb;
            dreq_wdata  = vecs[k].dwdata;
            mreq_ready  = vecs[k].rdy;
            mresp_valid = vecs[k].rv;
            mresp_data  = vecs[k].rdata;
            #3;
            check($sformatf("vec%0d.ctl", k), 64'(ctl_now()), 64'(vecs[k].ctl));
            if (vecs[k].ctl[4]) begin
                check($sformatf("vec%0d.maddr", k), mreq_addr, vecs[k].maddr);
                check($sformatf("vec%0d.mfields", k),
                      64'({mreq_write, mreq_size, mreq_strobe}),
                      64'({vecs[k].mwrite, vecs[k].msize, vecs[k].mstrb}));
                if (vecs[k].mwrite) begin
                    check($sformatf("vec%0d.mwdata", k), mreq_wdata, vecs[k].mwdata);
                end
            end
            check($sformatf("vec%0d.idata", k), 64'(iresp_data), 64'(vecs[k].idata));
            check($sformatf("vec%0d.ddata", k), dresp_data, vecs[k].ddata);
            @(posedge clk);
            #1;
        end

        // Both sides requesting continuously: D x LIMIT, then I, repeating.
        apply_reset();
        ireq_valid  = 1'b1;
        ireq_addr   = 64'h4000;
        dreq_valid  = 1'b1;
        dreq_addr   = 64'h5000;
        mreq_ready  = 1'b1;
        mresp_valid = 1'b1;
        mresp_data  = 64'h0102_0304_0506_0708;
        for (int c = 0; c < 60 && grants.size() < 10; c++) begin
            #3;
            if (iresp_addr_ok || dresp_addr_ok) grants.push_back(int'(iresp_addr_ok));
            @(posedge clk);
            #1;
        end
        check("starve.count", 64'(grants.size()), 64'd10);
        foreach (grants[k]) begin
            check($sformatf("starve.grant%0d_is_i", k), 64'(grants[k]),
                  64'((k % (LIMIT + 1)) == LIMIT));
        end

        // Reset while WAIT_D has a response arriving.
        apply_reset();
        dreq_valid = 1'b1;
        dreq_addr  = 64'h40;
        mreq_ready = 1'b1;
        @(posedge clk);
        #1;
        #3 check("rstwait.daok", 64'(dresp_addr_ok), 64'd1);
        dreq_valid = 1'b0;
        @(posedge clk);
        #1;
        mresp_valid = 1'b1;
        mresp_data  = 64'h55;
        #1 check("rstwait.ddok_before", 64'(dresp_data_ok), 64'd1);
        reset = 1'b1;
        #1 check_all_zero("rstwait.async");
        @(posedge clk);
        #1 reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #3 check($sformatf("rstwait.late_resp%0d", c), 64'(ctl_now()), 64'd0);
            check($sformatf("rstwait.latch%0d", c), mreq_addr, 64'd0);
            @(posedge clk);
            #1;
        end

        // Random traffic against a transaction-level model.
        apply_reset();
        starve = 0;
        for (int c = 0; c < 800; c++) begin
            iv  = ($urandom_range(0, 3) != 0);
            dv  = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            rv  = ($urandom_range(0, 1) != 0);
            ireq_valid  = iv;
            ireq_addr   = {$urandom, $urandom};
            dreq_valid  = dv;
            dreq_addr   = {$urandom, $urandom};
            dreq_size   = 3'($urandom_range(0, 3));
            dreq_strobe = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
            dreq_wdata  = {$urandom, $urandom};
            mreq_ready  = rdy;
            mresp_valid = rv;
            mresp_data  = {$urandom, $urandom};
            #3;

            e_ctl = C_NONE;
            e_id  = '0;
            e_dd  = '0;
            i_win = 1'b0;
            d_win = 1'b0;
            if (pend.size() == 0) begin
                i_win = iv && (!dv || starve == LIMIT);
                d_win = dv && !i_win;
            end else if (!pend[0].acc) begin
                e_ctl[4] = 1'b1;
                if (rdy) begin
                    if (pend[0].is_i) e_ctl[3] = 1'b1;
                    else              e_ctl[1] = 1'b1;
                end
            end else if (rv) begin
                if (pend[0].is_i) begin
                    e_ctl[2] = 1'b1;
                    e_id = pend[0].addr[2] ? mresp_data[63:32] : mresp_data[31:0];
                end else begin
                    e_ctl[0] = 1'b1;
                    e_dd = mresp_data;
                end
            end

            check($sformatf("rand%0d.ctl", c), 64'(ctl_now()), 64'(e_ctl));
            if (e_ctl[4]) begin
                check($sformatf("rand%0d.maddr", c), mreq_addr, pend[0].addr);
                check($sformatf("rand%0d.mfields", c),
                      64'({mreq_write, mreq_size, mreq_strobe}),
                      64'({pend[0].write, pend[0].size, pend[0].strb}));
                if (pend[0].write) begin
                    check($sformatf("rand%0d.mwdata", c), mreq_wdata, pend[0].wdata);
                end
            end
            check($sformatf("rand%0d.idata", c), 64'(iresp_data), 64'(e_id));
            check($sformatf("rand%0d.ddata", c), dresp_data, e_dd);

            if (i_win) begin
                pend.push_back('{1'b1, 1'b0, ireq_addr, 1'b0, 3'd2, 8'h00, 64'd0});
                starve = 0;
            end else if (d_win) begin
                pend.push_back('{1'b0, 1'b0, dreq_addr, |dreq_strobe, dreq_size, dreq_strobe,
                                 dreq_wdata});
                if (iv && starve < LIMIT) starve++;
            end else if (pend.size() != 0) begin
                if (!pend[0].acc && rdy) begin
                    t = pend[0];
                    t.acc = 1'b1;
                    pend[0] = t;
                end else if (pend[0].acc && rv) begin
                    void'(pend.pop_front());
                end
            end
            @(posedge clk);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one downstream memory port between the core's instruction-fetch side (I) and data-access side (D).
- Grants one requester at a time and latches its request, so only one transaction is outstanding.
- Translates between the core's addr_ok/data_ok bus protocol and a valid/ready request plus single-beat response downstream.
- Sits between the core's ibus/dbus outputs and the memory/cache interface.

Parameters:
- ADDR_W, 64, address width on all ports.
- STARVE_LIMIT, 4, consecutive D grants allowed while I is waiting before I is forced to win (range 1..15).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- ireq_valid  in  1  fetch request pending
- ireq_addr  in  ADDR_W  fetch address
- iresp_addr_ok  out  1  fetch request accepted downstream
- iresp_data_ok  out  1  fetch data valid
- iresp_data  out  32  fetched instruction
- dreq_valid  in  1  data request pending
- dreq_addr  in  ADDR_W  data address
- dreq_size  in  3  access size (log2 bytes, 0..3)
- dreq_strobe  in  8  byte write enables; all-zero means read
- dreq_wdata  in  64  write data
- dresp_addr_ok  out  1  data request accepted downstream
- dresp_data_ok  out  1  data response valid
- dresp_data  out  64  read data
- mreq_valid  out  1  downstream request valid
- mreq_ready  in  1  downstream accepts request
- mreq_addr  out  ADDR_W  downstream address
- mreq_write  out  1  1 = write (latched strobe != 0)
- mreq_size  out  3  access size
- mreq_strobe  out  8  byte enables
- mreq_wdata  out  64  write data
- mresp_valid  in  1  downstream response beat
- mresp_data  in  64  downstream read data

Behaviour:
- Reset (async, any state): FSM to IDLE, starvation counter to 0, request latches to 0.
  - All outputs 0 while reset is high and in the first IDLE cycle after it.
- FSM states: IDLE, REQ_I, REQ_D, WAIT_I, WAIT_D.
- IDLE, grant decision:
  - Only one requester valid: it wins.
  - Both valid: D wins, unless the starvation counter equals STARVE_LIMIT, in which case I wins.
  - On grant, latch the winner's request fields and move to REQ_x next cycle.
  - I grants: mreq_size = 3'd2 and mreq_strobe = 0.
  - No request: stay in IDLE.
- REQ_x:
  - mreq_valid = 1; mreq_* are driven from the latches and stay stable until mreq_ready.
  - When mreq_ready = 1: the matching x_addr_ok = 1 for exactly that cycle, and the FSM moves to WAIT_x.
- WAIT_x:
  - mreq_valid = 0.
  - When mresp_valid = 1: x_data_ok = 1 that cycle (combinational), then IDLE next cycle.
  - A mresp_valid arriving in any other state is ignored.
- Response data:
  - iresp_data = mresp_data[63:32] if the latched addr[2] = 1, else mresp_data[31:0].
  - dresp_data = mresp_data unmodified.
  - Both data outputs are 0 whenever the matching data_ok = 0.
- Starvation counter (4 bits):
  - Increments on each D grant made while ireq_valid = 1; saturates at STARVE_LIMIT.
  - Clears on any I grant.
  - Holds on a D grant made with ireq_valid = 0.
- Latency:
  - Minimum 2 cycles from grant cycle to data_ok: grant at T, REQ at T+1 with ready, WAIT at T+2 with mresp_valid.
  - Back-to-back transactions have one IDLE cycle between them.
- Upstream behaviour:
  - Requesters hold valid and fields until addr_ok.
  - If an upstream valid drops after grant, the latched transaction still completes and data_ok still pulses.
  - The arbiter never aborts a granted transaction.
- A requester not currently granted sees addr_ok = data_ok = 0.
- The same requester may be re-granted in the IDLE cycle right after its data_ok.

Decomposition:
- Shared package (common): mem_req_t struct {addr, write, size, strobe, wdata}, arb_state_t enum, MSIZE_WORD = 3'd2 constant.
- Natural sub-module: arb_starve_ctr (saturating counter plus force_i output), instantiated once.

Test Plan:
- Single fetch, ireq_addr = 0x8000_0004, mreq_ready = 1 immediately, mresp_data = 0x1111_2222_3333_4444 one cycle later:
  - mreq_size = 2, mreq_strobe = 0.
  - iresp_addr_ok pulses at T+1.
  - iresp_data_ok at T+2 with iresp_data = 0x1111_2222.
- Data write, addr 0x8000_0010, strobe 0x0F, wdata 0xDEAD_BEEF, mreq_ready held low 3 cycles:
  - mreq_write = 1 and all fields stable for all 4 REQ cycles.
  - dresp_addr_ok is a single pulse.
- Both valid continuously, STARVE_LIMIT = 4:
  - Grant order is D, D, D, D, I, then the counter restarts.
  - I is never starved for more than 4 D transactions.
- ireq_valid dropped the cycle after grant:
  - The transaction still completes.
  - iresp_data_ok still pulses with the correct data.
- Reset asserted while in WAIT_D (mresp pending):
  - All outputs 0 immediately (asynchronous), FSM in IDLE.
  - A mresp_valid arriving later produces no data_ok.
- mresp_valid pulsed while in IDLE or REQ_I: no data_ok on either side, state unchanged.
